// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding,
// mode constants and the chunk-counter sizing helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Counter width is max(1, ceil(log2(n))) so a single-step operation still gets a real register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple-carry adder built from full_adder cells; the serial
// datapath reuses one instance for every chunk step.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .cin(c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple-carry chunk adder.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle through a single
// shared chunk adder, with a valid/ready request and response handshake.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             lt
);

  localparam int N  = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || WIDTH < 1) begin : g_bad_params
    $error("addsub_serial: WIDTH must be a positive multiple of CHUNK and CHUNK >= 1");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_r;
  logic             mode_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] chunk_x;
  logic [CHUNK-1:0] chunk_y;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             accept;
  logic             last_step;

  assign accept    = in_valid & in_ready;
  assign last_step = (state == BUSY) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign chunk_x = op_a[int'(cnt)*CHUNK +: CHUNK];
  assign chunk_y = op_b[int'(cnt)*CHUNK +: CHUNK];

  addsub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x  (chunk_x),
    .y  (chunk_y),
    .cin(carry),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // Subtraction is a + ~b + 1: b is inverted once at accept and the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      mode_r <= MODE_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
    end else if (accept) begin
      op_a   <= a;
      op_b   <= (mode == MODE_SUB) ? ~b : b;
      mode_r <= mode;
      carry  <= mode;
      cnt    <= '0;
    end else if (state == BUSY) begin
      sum_r[int'(cnt)*CHUNK +: CHUNK] <= chunk_s;
      carry <= chunk_co;
      if (!last_step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Flags are derived from the full registered result and only asserted alongside out_valid.
  assign result = sum_r;
  assign cout   = out_valid & carry;
  assign zero   = out_valid & (sum_r == '0);
  assign lt     = out_valid & (mode_r == MODE_SUB) & ~carry;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: three instances (32/8, 32/32, 16/1) checked
// against an arithmetic reference model, plus directed stall and reset-abort scenarios.
module tb_addsub_serial;
  import addsub_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        lt;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b1;
  logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic        rand_ready = 1'b0;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [31:0] res0, res1;
  logic [15:0] res2;
  logic        co0, co1, co2, zr0, zr1, zr2, lt0, lt1, lt2;

  logic        ov [3];
  logic [31:0] res [3];
  logic        co [3];
  logic        zr [3];
  logic        ltf [3];
  logic        ov_prev [3] = '{1'b0, 1'b0, 1'b0};
  int          lat_n [3] = '{4, 1, 16};
  int          acc [3] = '{0, 0, 0};

  resp_t q0[$], q1[$], q2[$];
  int    n_vec = 0;
  int    n_mis = 0;
  int    cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer back-pressure during the random phase
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  addsub_serial #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .mode(mode), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .result(res0), .cout(co0), .zero(zr0), .lt(lt0));

  addsub_serial #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .mode(mode), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .cout(co1), .zero(zr1), .lt(lt1));

  addsub_serial #(.WIDTH(16), .CHUNK(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .mode(mode), .a(a[15:0]), .b(b[15:0]),
    .out_valid(ov2), .out_ready(out_ready), .result(res2), .cout(co2), .zero(zr2), .lt(lt2));

  always_comb begin
    ov[0] = ov0;  ov[1] = ov1;  ov[2] = ov2;
    res[0] = res0; res[1] = res1; res[2] = {16'h0000, res2};
    co[0] = co0;  co[1] = co1;  co[2] = co2;
    zr[0] = zr0;  zr[1] = zr1;  zr[2] = zr2;
    ltf[0] = lt0; ltf[1] = lt1; ltf[2] = lt2;
  end

  // Reference: plain unsigned arithmetic modulo 2^w
  function automatic resp_t model(input int w, input logic m, input logic [31:0] x, input logic [31:0] y);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned ux = {32'h0, x} & mask;
    longint unsigned uy = {32'h0, y} & mask;
    longint unsigned s;
    resp_t r;
    if (m == MODE_ADD) begin
      s = ux + uy;
      r.result = 32'(s & mask);
      r.cout   = (s > mask);
      r.lt     = 1'b0;
    end else begin
      r.result = 32'((ux - uy) & mask);
      r.cout   = (ux >= uy);
      r.lt     = (ux < uy);
    end
    r.zero = (r.result == 32'h0);
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checkOutput(input int k, input resp_t exp);
    checkVal($sformatf("result%0d", k), 64'(res[k]), 64'(exp.result));
    checkVal($sformatf("cout%0d", k),   64'(co[k]),  64'(exp.cout));
    checkVal($sformatf("zero%0d", k),   64'(zr[k]),  64'(exp.zero));
    checkVal($sformatf("lt%0d", k),     64'(ltf[k]), 64'(exp.lt));
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic resp_t qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: latency on every out_valid rise, scoreboard pop on every handshake
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && !ov_prev[k])
          checkVal($sformatf("latency%0d", k), 64'(cyc - acc[k]), 64'(lat_n[k]));
        if (ov[k] && out_ready) begin
          if (qsize(k) == 0) checkVal($sformatf("spurious_out%0d", k), 64'd1, 64'd0);
          else checkOutput(k, qpop(k));
        end
      end
    end
    for (int k = 0; k < 3; k++) ov_prev[k] = ov[k];
  end

  task automatic applyStimulus(input logic m, input logic [31:0] x, input logic [31:0] y,
                               input bit push, input resp_t exp);
    int t = 0;
    while (!rdy0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!rdy0) begin
      checkVal("ready_timeout0", 64'd0, 64'd1);
      return;
    end
    mode = m; a = x; b = y; iv0 = 1'b1;
    @(posedge clk); #1;
    acc[0] = cyc;
    iv0 = 1'b0;
    if (push) q0.push_back(exp);
  endtask

  task automatic waitDrain(input int budget);
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < budget) begin
      @(posedge clk); t++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0)
      checkVal("drain_timeout", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    logic [31:0] x, y;
    logic m;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkVal("rst_in_ready0",  64'(rdy0), 64'd1);
    checkVal("rst_out_valid0", 64'(ov0),  64'd0);
    checkVal("rst_result0",    64'(res0), 64'd0);
    checkVal("rst_cout0",      64'(co0),  64'd0);
    checkVal("rst_zero0",      64'(zr0),  64'd0);
    checkVal("rst_lt0",        64'(lt0),  64'd0);
    checkVal("rst_in_ready1",  64'(rdy1), 64'd1);
    checkVal("rst_in_ready2",  64'(rdy2), 64'd1);

    applyStimulus(MODE_SUB, 32'd100, 32'd36, 1'b1, {32'd64, 1'b1, 1'b0, 1'b0});
    applyStimulus(MODE_SUB, 32'd5, 32'd7, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1});
    applyStimulus(MODE_SUB, 32'd9, 32'd9, 1'b1, {32'd0, 1'b1, 1'b1, 1'b0});
    applyStimulus(MODE_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, {32'd0, 1'b1, 1'b1, 1'b0});
    // Carry out of chunk 1 ripples into chunk 2
    applyStimulus(MODE_ADD, 32'h00FF_00FF, 32'h0001_FF01, 1'b1, {32'h0101_0000, 1'b0, 1'b0, 1'b0});
    waitDrain(200);

    // Hold the result in DONE while inputs churn
    out_ready = 1'b0;
    applyStimulus(MODE_SUB, 32'd50, 32'd8, 1'b1, {32'd42, 1'b1, 1'b0, 1'b0});
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!ov0 && t < 50);
    checkVal("stall_reach_done", 64'(ov0), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; mode = ~mode; iv0 = 1'b1;
      @(negedge clk);
      checkVal("stall_result",   64'(res0), 64'd42);
      checkVal("stall_cout",     64'(co0),  64'd1);
      checkVal("stall_zero",     64'(zr0),  64'd0);
      checkVal("stall_lt",       64'(lt0),  64'd0);
      checkVal("stall_in_ready", 64'(rdy0), 64'd0);
      checkVal("stall_valid",    64'(ov0),  64'd1);
    end
    @(posedge clk); #1;
    iv0 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkVal("idle_in_ready",  64'(rdy0), 64'd1);
    checkVal("idle_out_valid", 64'(ov0),  64'd0);

    // Abort mid-operation with reset, then issue a fresh request right away
    applyStimulus(MODE_SUB, 32'd7, 32'd3, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkVal("abort_in_ready",  64'(rdy0), 64'd1);
    checkVal("abort_out_valid", 64'(ov0),  64'd0);
    checkVal("abort_result",    64'(res0), 64'd0);
    applyStimulus(MODE_SUB, 32'd1000, 32'd1, 1'b1, {32'd999, 1'b1, 1'b0, 1'b0});
    waitDrain(200);

    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      t = 0;
      while (!(rdy0 && rdy1 && rdy2) && t < 300) begin
        @(posedge clk); #1; t++;
      end
      if (!(rdy0 && rdy1 && rdy2)) begin
        checkVal("ready_timeout_all", 64'd0, 64'd1);
        break;
      end
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? x : $urandom;
      if ($urandom_range(0, 15) == 0) x = 32'hFFFF_FFFF;
      m = 1'($urandom_range(0, 1));
      mode = m; a = x; b = y;
      iv0 = 1'b1; iv1 = 1'b1; iv2 = 1'b1;
      @(posedge clk); #1;
      acc[0] = cyc; acc[1] = cyc; acc[2] = cyc;
      iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
      q0.push_back(model(32, m, x, y));
      q1.push_back(model(32, m, x, y));
      q2.push_back(model(16, m, x, y));
    end
    waitDrain(2000);
    rand_ready = 1'b0;
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
